// File: rtl/dbus_peri_initiator.sv
// Peripheral data-bus initiator: decodes single core load/store requests to a
// one-hot responder select and runs one timeout-protected transaction per request.
module dbus_peri_initiator #(
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         N_PERI    = 5,
  parameter logic [ADDR_W-1:0]   PERI_BASE = 32'h9000_0000,
  parameter int unsigned         SPAN_LOG2 = 8,
  parameter int unsigned         TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_req_i,
  input  logic                     core_we_i,
  input  logic [ADDR_W-1:0]        core_addr_i,
  input  logic [DATA_W-1:0]        core_wdata_i,
  input  logic [DATA_W/8-1:0]      core_be_i,
  output logic                     core_ready_o,
  output logic                     core_rsp_valid_o,
  output logic [DATA_W-1:0]        core_rdata_o,
  output logic                     core_err_o,
  output logic [N_PERI-1:0]        peri_sel_o,
  output logic                     peri_req_o,
  output logic                     peri_we_o,
  output logic [SPAN_LOG2-1:0]     peri_addr_o,
  output logic [DATA_W-1:0]        peri_wdata_o,
  output logic [DATA_W/8-1:0]      peri_be_o,
  input  logic [N_PERI-1:0]        peri_ack_i,
  input  logic [N_PERI*DATA_W-1:0] peri_rdata_i
);

  localparam int unsigned IDX_W = $clog2(N_PERI);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  ofs, slot;
  logic               hit, ack_sel, timeout_hit;
  logic [DATA_W-1:0]  rdata_sel;

  // Address decode: window offset, responder slot, alignment
  assign ofs = core_addr_i - PERI_BASE;
  assign slot = ofs >> SPAN_LOG2;
  assign hit = (core_addr_i >= PERI_BASE) && (slot < ADDR_W'(N_PERI))
               && (core_addr_i[1:0] == 2'b00);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Only the selected responder's ack and read data are observed
  always_comb begin
    ack_sel = 1'b0;
    rdata_sel = '0;
    for (int unsigned i = 0; i < N_PERI; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ack_sel = peri_ack_i[i];
        rdata_sel = peri_rdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (core_req_i) state_d = hit ? S_ACCESS : S_RESP;
      end
      S_ACCESS: begin
        if (ack_sel || timeout_hit) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_ready_o = 1'b0;
    core_rsp_valid_o = 1'b0;
    peri_req_o = 1'b0;
    peri_sel_o = '0;
    case (state_q)
      S_IDLE:   core_ready_o = 1'b1;
      S_ACCESS: begin
        peri_req_o = 1'b1;
        peri_sel_o = N_PERI'(1) << idx_q;
      end
      S_RESP:   core_rsp_valid_o = 1'b1;
      default:  ;
    endcase
  end

  // Transaction latches, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
      peri_we_o <= 1'b0;
      peri_addr_o <= '0;
      peri_wdata_o <= '0;
      peri_be_o <= '0;
      core_rdata_o <= '0;
      core_err_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (core_req_i) begin
            if (hit) begin
              peri_we_o <= core_we_i;
              peri_addr_o <= ofs[SPAN_LOG2-1:0];
              peri_wdata_o <= core_wdata_i;
              peri_be_o <= core_be_i;
              idx_q <= IDX_W'(slot);
              cnt_q <= '0;
            end else begin
              core_rdata_o <= '0;
              core_err_o <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (ack_sel) begin
            core_rdata_o <= peri_we_o ? '0 : rdata_sel;
            core_err_o <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (timeout_hit) begin
              core_rdata_o <= '0;
              core_err_o <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_peri_initiator.sv
// Directed bench for dbus_peri_initiator: table of single transactions plus
// hand-written reset-during-access sequence.
module tb_dbus_peri_initiator;

  logic          clk;
  logic          rst;
  logic          core_req_i;
  logic          core_we_i;
  logic [31:0]   core_addr_i;
  logic [31:0]   core_wdata_i;
  logic [3:0]    core_be_i;
  logic          core_ready_o;
  logic          core_rsp_valid_o;
  logic [31:0]   core_rdata_o;
  logic          core_err_o;
  logic [4:0]    peri_sel_o;
  logic          peri_req_o;
  logic          peri_we_o;
  logic [7:0]    peri_addr_o;
  logic [31:0]   peri_wdata_o;
  logic [3:0]    peri_be_o;
  logic [4:0]    peri_ack_i;
  logic [159:0]  peri_rdata_i;

  int n_tests = 0;
  int n_fail = 0;

  dbus_peri_initiator dut (
    .clk(clk),
    .rst(rst),
    .core_req_i(core_req_i),
    .core_we_i(core_we_i),
    .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i),
    .core_be_i(core_be_i),
    .core_ready_o(core_ready_o),
    .core_rsp_valid_o(core_rsp_valid_o),
    .core_rdata_o(core_rdata_o),
    .core_err_o(core_err_o),
    .peri_sel_o(peri_sel_o),
    .peri_req_o(peri_req_o),
    .peri_we_o(peri_we_o),
    .peri_addr_o(peri_addr_o),
    .peri_wdata_o(peri_wdata_o),
    .peri_be_o(peri_be_o),
    .peri_ack_i(peri_ack_i),
    .peri_rdata_i(peri_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One transaction: dly = ACCESS cycle index carrying the ack (-1 = never),
  // noise = foreign ack bits pulsed before the real ack, idx = -1 for a miss.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dly;
    logic [4:0]  noise;
    logic [31:0] slice;
    int          idx;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v);
    int cyc;
    logic [4:0] exp_sel;
    @(negedge clk);
    chk("ready_before", 64'(core_ready_o), 64'd1);
    core_req_i = 1'b1;
    core_we_i = v.we;
    core_addr_i = v.addr;
    core_wdata_i = v.wdata;
    core_be_i = v.be;
    for (int i = 0; i < 5; i++) peri_rdata_i[i*32 +: 32] = 32'h1111_1111 * (i + 1);
    if (v.idx >= 0) peri_rdata_i[v.idx*32 +: 32] = v.slice;
    peri_ack_i = '0;
    @(negedge clk);
    core_req_i = 1'b0;
    exp_sel = '0;
    if (v.idx >= 0) exp_sel[v.idx] = 1'b1;
    cyc = 0;
    while (peri_req_o === 1'b1 && cyc <= 40) begin
      chk("acc_sel", 64'(peri_sel_o), 64'(exp_sel));
      chk("acc_hold", 64'({peri_we_o, peri_addr_o, peri_wdata_o, peri_be_o, core_rsp_valid_o}),
          64'({v.we, v.addr[7:0], v.wdata, v.be, 1'b0}));
      peri_ack_i = '0;
      if (v.dly >= 0 && cyc == v.dly) peri_ack_i[v.idx] = 1'b1;
      else if (v.dly < 0 || cyc < v.dly) peri_ack_i = v.noise;
      cyc++;
      @(negedge clk);
    end
    chk("access_cycles", 64'(cyc), 64'(v.exp_cyc));
    chk("rsp", 64'({core_rsp_valid_o, core_err_o, core_rdata_o, peri_req_o, peri_sel_o}),
        64'({1'b1, v.exp_err, v.exp_rdata, 1'b0, 5'b0}));
    // Acks during RESP and IDLE must be ignored
    peri_ack_i = '1;
    @(negedge clk);
    chk("idle_after", 64'({core_rsp_valid_o, core_ready_o, peri_req_o}), 64'(3'b010));
    peri_ack_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h9000_0204, 32'h0, 4'hF, 0, 5'b0, 32'hA5A5_0F0F, 2, 1, 1'b0, 32'hA5A5_0F0F};
    vecs[1] = '{1'b1, 32'h9000_0000, 32'h0000_00FF, 4'b0001, 3, 5'b0, 32'hDEAD_BEEF, 0, 4, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h8FFF_FFFC, 32'h0, 4'hF, -1, 5'b0, 32'h0, -1, 0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h9000_0500, 32'h0, 4'hF, -1, 5'b0, 32'h0, -1, 0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 32'h9000_0102, 32'h1234, 4'hF, -1, 5'b0, 32'h0, -1, 0, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h9000_0110, 32'h0, 4'hF, -1, 5'b0, 32'h7777_7777, 1, 15, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 32'h9000_0308, 32'h0, 4'hF, 2, 5'b10001, 32'h1234_5678, 3, 3, 1'b0, 32'h1234_5678};
    vecs[7] = '{1'b0, 32'h9000_04FC, 32'h0, 4'b1100, 1, 5'b0, 32'hCAFE_F00D, 4, 2, 1'b0, 32'hCAFE_F00D};
    vecs[8] = '{1'b0, 32'h9000_0100, 32'h0, 4'hF, 14, 5'b0, 32'h0BAD_F00D, 1, 15, 1'b0, 32'h0BAD_F00D};
    vecs[9] = '{1'b0, 32'h0000_0000, 32'h0, 4'hF, -1, 5'b0, 32'h0, -1, 0, 1'b1, 32'h0};

    rst = 1'b1;
    core_req_i = 1'b0;
    core_we_i = 1'b0;
    core_addr_i = '0;
    core_wdata_i = '0;
    core_be_i = '0;
    peri_ack_i = '0;
    peri_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 64'({core_ready_o, core_rsp_valid_o, core_err_o, peri_req_o, peri_sel_o, peri_we_o}),
        64'(10'b10_0000_0000));
    chk("reset_data", 64'({peri_addr_o, peri_wdata_o, peri_be_o}), 64'd0);
    chk("reset_rdata", 64'(core_rdata_o), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) do_txn(vecs[k]);

    // Reset in the 2nd ACCESS cycle drops the pending write
    @(negedge clk);
    core_req_i = 1'b1;
    core_we_i = 1'b1;
    core_addr_i = 32'h9000_0104;
    core_wdata_i = 32'h5555_AAAA;
    core_be_i = 4'hF;
    @(negedge clk);
    core_req_i = 1'b0;
    chk("mid_rst_access", 64'({peri_req_o, peri_sel_o}), 64'(6'b1_00010));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ctl", 64'({core_ready_o, core_rsp_valid_o, peri_req_o, peri_sel_o, peri_we_o}),
        64'(9'b1_0000_0000));
    chk("mid_rst_data", 64'({peri_addr_o, peri_wdata_o, peri_be_o}), 64'd0);
    @(negedge clk);
    chk("mid_rst_no_rsp", 64'({core_rsp_valid_o, core_ready_o}), 64'(2'b01));
    do_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
